hms_display_scan: RTL and testbench
===================================

// Module: hms_display_scan
// PURPOSE
//   Reads the time-of-day outputs (hour/min/sec, binary) and drives a 6-digit multiplexed
//   7-segment display as HH MM SS. It converts each field to BCD, scans one digit per slot,
//   and inserts a blanking cycle between digits. It snapshots the time once per frame so
//   that a single frame never mixes old and new values.
// PARAMETERS
//   CLK_HZ      50000000  input clock frequency, Hz
//   SCAN_HZ     6000      digit-slot rate, Hz (frame rate = SCAN_HZ/6); SCAN_HZ <= CLK_HZ/2
//   ACTIVE_LOW  1         1: seg/dp/an asserted low (common anode); 0: asserted high
// PORTS
//   clk         in   1   system clock
//   rst         in   1   reset; asynchronous, active-high
//   sec         in   6   seconds, binary, valid range 0..59
//   min         in   6   minutes, binary, valid range 0..59
//   hour        in   5   hours, binary, valid range 0..23
//   seg         out  7   segments {g,f,e,d,c,b,a}
//   dp          out  1   decimal point of the active digit
//   an          out  6   digit enables; an[0]=sec ones ... an[5]=hour tens
//   frame_start out  1   1-cycle pulse when digit 0 begins a new frame
// BEHAVIOUR
//   - Reset behaviour (async): all outputs go deasserted, i.e. an/seg/dp = inactive level
//     (all 1s when ACTIVE_LOW=1). frame_start=0. Digit index=0, state=DRIVE, tick count=0.
//     The shadow time is cleared to 00:00:00. Reset mid-frame aborts the frame immediately.
//   - Tick: TICK_MAX = CLK_HZ/SCAN_HZ - 1. The counter runs 0..TICK_MAX while in DRIVE.
//   - FSM, 2 states:
//     DRIVE: the current digit is enabled. When count==TICK_MAX, go to BLANK and clear count.
//     BLANK: exactly 1 cycle with all an inactive and seg inactive.
//            Then idx <= (idx==5) ? 0 : idx+1, and the FSM returns to DRIVE.
//     Each digit slot therefore lasts TICK_MAX+2 cycles.
//   - Snapshot: in the BLANK cycle with idx==5, sec/min/hour are captured into the shadow.
//     frame_start=1 on the following cycle, which is the first DRIVE cycle of digit 0.
//     All digits of a frame come from one snapshot.
//   - BCD: tens=v/10, ones=v%10 per field. The hour tens digit shows 0 (no leading blank).
//   - Invalid field: sec>59, min>59 or hour>23 makes both digits of that field show '-'
//     (segment g only). Other fields are unaffected.
//   - Segment map (active-high form, {g..a}):
//       0=0111111  1=0000110  2=1011011  3=1001111  4=1100110
//       5=1101101  6=1111101  7=0000111  8=1111111  9=1101111
//       '-'=1000000
//     When ACTIVE_LOW=1 the outputs are bitwise inverted.
//   - Outputs are registered. seg/an/dp reflect the state/idx of the previous cycle
//     (1-cycle latency). No combinational path from sec/min/hour to any output.
// CONFIGURATION
//   HMS_COLON_BLINK_EN defined:
//     - dp is asserted on digits 2 and 4 (the HH.MM.SS separators) while shadow sec[0]==0,
//       so the separators toggle at 1 Hz.
//     - dp stays deasserted on all other digits, on invalid frames, and during BLANK.
//   HMS_COLON_BLINK_EN undefined:
//     - dp is held deasserted permanently; the blink logic is not synthesized.
// TESTING  (CLK_HZ=1000, SCAN_HZ=100 -> TICK_MAX=9, 11-cycle slots, ACTIVE_LOW=1)
//   1. Reset: assert rst mid-DRIVE.
//      -> same cycle: an=6'b111111, seg=7'b1111111, dp=1, frame_start=0.
//      -> after release: digit 0 drives first.
//   2. hour=12, min=34, sec=56, run 2 frames.
//      -> second frame, digits 0..5 show 6,5,4,3,2,1.
//      -> digit 0: an=6'b111110, seg=7'b0000010.
//   3. Slot timing.
//      -> each an pattern is held 10 cycles, then exactly 1 cycle of an=6'b111111.
//      -> frame_start pulses every 66 cycles.
//   4. Anti-tear: change sec 56->57 while digit 2 is driven.
//      -> digits 0/1 keep showing 6/5 for the rest of the frame.
//      -> the next frame shows 7/5.
//   5. Invalid input: min=60, hour=23, sec=0.
//      -> an[2], an[3] slots show seg=7'b0111111 ('-').
//      -> hours show 2,3; seconds show 0,0.
//   6. HMS_COLON_BLINK_EN defined, sec=10: dp=0 on digits 2 and 4, dp=1 elsewhere.
//      sec=11: dp=1 on all digits.
//      Macro undefined: dp=1 on all digits for both values.

Source files
------------

// File: rtl/hms_display_scan.sv
// Multiplexed HH MM SS display driver: binary-to-BCD, one digit per slot with a blank
// cycle between digits. The time is snapshotted once per frame. Optional: HMS_COLON_BLINK_EN.
module hms_display_scan #(
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 6000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int TICK_MAX = CLK_HZ / SCAN_HZ - 1;
    localparam int CW       = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CW-1:0] TICK_END = CW'(TICK_MAX);

    // XOR masks: a 1 here inverts the active-high form into the pin polarity
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0] AN_OFF  = ACTIVE_LOW ? 6'h3F : 6'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;
    localparam logic [3:0] DASH    = 4'd10;

    typedef enum logic {DRIVE = 1'b0, BLANK = 1'b1} state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] count_r, count_s;
    logic [2:0]    idx_r, idx_s;
    logic [5:0]    sh_sec_r, sh_min_r;
    logic [4:0]    sh_hour_r;

    logic [3:0]    code_s;
    logic [6:0]    seg_hi_s;
    logic [5:0]    an_hi_s;
    logic          dp_hi_s;
    logic          sec_ok_s, min_ok_s, hour_ok_s;
    logic [6:0]    seg_s;
    logic [5:0]    an_s;
    logic          dp_s;
    logic          frame_start_s;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [6:0] seg_map(input logic [3:0] code);
        case (code)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // State, tick counter and digit index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DRIVE;
            count_r <= '0;
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state: DRIVE for TICK_MAX+1 cycles, then one BLANK cycle advancing the digit
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        idx_s   = idx_r;
        case (state_r)
            DRIVE: begin
                if (count_r == TICK_END) begin
                    state_s = BLANK;
                    count_s = '0;
                end else begin
                    count_s = count_r + CW'(1);
                end
            end
            BLANK: begin
                state_s = DRIVE;
                count_s = '0;
                idx_s   = (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
            end
            default: begin
                state_s = DRIVE;
                count_s = '0;
                idx_s   = 3'd0;
            end
        endcase
    end

    // Frame snapshot, taken in the blank slot that ends digit 5
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_sec_r  <= 6'd0;
            sh_min_r  <= 6'd0;
            sh_hour_r <= 5'd0;
        end else if ((state_r == BLANK) && (idx_r == 3'd5)) begin
            sh_sec_r  <= sec;
            sh_min_r  <= min;
            sh_hour_r <= hour;
        end else begin
            sh_sec_r  <= sh_sec_r;
            sh_min_r  <= sh_min_r;
            sh_hour_r <= sh_hour_r;
        end
    end

    // Output decode from the snapshot and current slot
    always_comb begin
        sec_ok_s  = (sh_sec_r <= 6'd59);
        min_ok_s  = (sh_min_r <= 6'd59);
        hour_ok_s = (sh_hour_r <= 5'd23);
        code_s    = DASH;
        an_hi_s   = 6'b000000;
        case (idx_r)
            3'd0: begin code_s = sec_ok_s  ? bcd_ones(sh_sec_r)          : DASH; an_hi_s = 6'b000001; end
            3'd1: begin code_s = sec_ok_s  ? bcd_tens(sh_sec_r)          : DASH; an_hi_s = 6'b000010; end
            3'd2: begin code_s = min_ok_s  ? bcd_ones(sh_min_r)          : DASH; an_hi_s = 6'b000100; end
            3'd3: begin code_s = min_ok_s  ? bcd_tens(sh_min_r)          : DASH; an_hi_s = 6'b001000; end
            3'd4: begin code_s = hour_ok_s ? bcd_ones({1'b0, sh_hour_r}) : DASH; an_hi_s = 6'b010000; end
            3'd5: begin code_s = hour_ok_s ? bcd_tens({1'b0, sh_hour_r}) : DASH; an_hi_s = 6'b100000; end
            default: begin code_s = DASH; an_hi_s = 6'b000000; end
        endcase
        seg_hi_s = seg_map(code_s);
`ifdef HMS_COLON_BLINK_EN
        dp_hi_s = ((idx_r == 3'd2) || (idx_r == 3'd4)) && !sh_sec_r[0]
                  && sec_ok_s && min_ok_s && hour_ok_s;
`else
        dp_hi_s = 1'b0;
`endif
        if (state_r == DRIVE) begin
            seg_s = seg_hi_s ^ SEG_OFF;
            an_s  = an_hi_s ^ AN_OFF;
            dp_s  = dp_hi_s ^ DP_OFF;
        end else begin
            seg_s = SEG_OFF;
            an_s  = AN_OFF;
            dp_s  = DP_OFF;
        end
        frame_start_s = (state_r == BLANK) && (idx_r == 3'd5);
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            dp          <= DP_OFF;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_s;
            an          <= an_s;
            dp          <= dp_s;
            frame_start <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_hms_display_scan.sv
// Randomized self-checking bench for hms_display_scan (1 kHz clock, 100 Hz slots,
// active-low outputs), compared each cycle against a frame/slot arithmetic model.
module tb_hms_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] sec, min;
    logic [4:0] hour;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_start;

    int errors = 0;
    int checks = 0;
    int n = 0;
    int m_sec = 0, m_min = 0, m_hour = 0;

    logic [6:0] segtab [0:10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                 7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                 7'b1111111, 7'b1101111, 7'b1000000};

    hms_display_scan #(.CLK_HZ(1000), .SCAN_HZ(100), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hour(hour),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    // One clock: predict what the outputs show for the current slot position, then compare
    task automatic step();
        int p, slot, w, v, lim, dig;
        bit ok, all_ok;
        logic [5:0] one;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fs;
        p = n % 66; slot = p / 11; w = p % 11;
        one = 6'd1;
        e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
        e_fs = (p == 65);
        if (w < 10) begin
            case (slot / 2)
                0: begin v = m_sec;  lim = 59; end
                1: begin v = m_min;  lim = 59; end
                default: begin v = m_hour; lim = 23; end
            endcase
            ok = (v <= lim);
            dig = (slot % 2 == 1) ? v / 10 : v % 10;
            e_seg = ok ? ~segtab[dig] : ~7'b1000000;
            e_an = ~(one << slot);
            all_ok = (m_sec <= 59) && (m_min <= 59) && (m_hour <= 23);
`ifdef HMS_COLON_BLINK_EN
            if ((slot == 2 || slot == 4) && (m_sec % 2 == 0) && all_ok) e_dp = 1'b0;
`endif
        end
        if (p == 65) begin
            m_sec = sec; m_min = min; m_hour = hour;
        end
        @(posedge clk);
        #1;
        check("an", {2'b00, an}, {2'b00, e_an});
        check("seg", {1'b0, seg}, {1'b0, e_seg});
        check("dp", {7'd0, dp}, {7'd0, e_dp});
        check("frame_start", {7'd0, frame_start}, {7'd0, e_fs});
        n++;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        m_sec = 0; m_min = 0; m_hour = 0;
    endtask

    // Reset asserted in the middle of a driven digit must blank everything at once
    task automatic mid_reset();
        while ((n % 11) >= 8 || (n % 11) < 2) step();
        #2;
        rst = 1'b1;
        #1;
        check("rst_an", {2'b00, an}, 8'h3F);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_dp", {7'd0, dp}, 8'h01);
        check("rst_fs", {7'd0, frame_start}, 8'h00);
        release_reset();
    endtask

    initial begin
        rst = 1'b1;
        sec = 6'd0; min = 6'd0; hour = 5'd0;
        #12;
        check("rst_an", {2'b00, an}, 8'h3F);
        check("rst_seg", {1'b0, seg}, 8'h7F);
        check("rst_dp", {7'd0, dp}, 8'h01);
        check("rst_fs", {7'd0, frame_start}, 8'h00);
        release_reset();

        hour = 5'd12; min = 6'd34; sec = 6'd56;
        run(132);
        run(25);
        sec = 6'd57;
        run(41 + 66);

        min = 6'd60; hour = 5'd23; sec = 6'd0;
        run(132);

        min = 6'd34; hour = 5'd12; sec = 6'd10;
        run(132);
        sec = 6'd11;
        run(132);

        mid_reset();
        hour = 5'd9; min = 6'd5; sec = 6'd48;
        run(70);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                sec  = 6'($urandom_range(0, 59));
                min  = 6'($urandom_range(0, 59));
                hour = 5'($urandom_range(0, 23));
            end else begin
                sec  = 6'($urandom_range(0, 63));
                min  = 6'($urandom_range(0, 63));
                hour = 5'($urandom_range(0, 31));
            end
            run($urandom_range(1, 90));
            if (it % 8 == 7) mid_reset();
        end
        run(140);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
